// File: rtl/smg_pkg.sv
// Shared constants and helpers for the seven-segment scan family.
package smg_pkg;

    // CLK cycles in 1 ms at a 50 MHz clock
    localparam int T1MS_50MHZ = 50000;

    // Width of one BCD digit
    localparam int BCD_W = 4;

    // Ceiling log2 that never returns less than 1, so a counter always has a bit
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/smg_lz_mask.sv
// Leading-zero suppression mask: bit k set means digit k should stay dark.
// Digit 0 and any digit carrying a decimal point are always shown.
module smg_lz_mask
    import smg_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic [BCD_W*DIGITS-1:0] i_digits,
    input  logic [DIGITS-1:0]       i_dp,
    input  logic                    i_lz_en,
    output logic [DIGITS-1:0]       o_mask
);

    logic w_chain;

    // Walk from the most significant digit down, tracking whether all digits so far are zero
    always_comb begin
        o_mask  = '0;
        w_chain = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_chain = w_chain & (i_digits[k*BCD_W +: BCD_W] == {BCD_W{1'b0}});
            if ((k != 0) && i_lz_en && w_chain && !i_dp[k]) begin
                o_mask[k] = 1'b1;
            end else begin
                o_mask[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one slot of SCAN_TICKS cycles per
// digit, most significant digit first, with a dark gap at the start of each slot.
// Inputs are snapshotted once per frame so a frame never mixes two numbers.
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int SCAN_TICKS   = T1MS_50MHZ,
    parameter int GAP_TICKS    = 2,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    Enable,
    input  logic [BCD_W*DIGITS-1:0] Number_Sig,
    input  logic [DIGITS-1:0]       Dp_Sig,
    input  logic [DIGITS-1:0]       Blink_En,
    input  logic                    Lz_En,
    output logic [BCD_W-1:0]        Number_Data,
    output logic                    Dp_Out,
    output logic [DIGITS-1:0]       Scan_Sel,
    output logic                    Blank,
    output logic                    Frame_Done
);

    localparam int C1_W  = clog2_min1(SCAN_TICKS);
    localparam int IDX_W = clog2_min1(DIGITS);
    localparam int FC_W  = clog2_min1(BLINK_FRAMES);

    localparam logic [C1_W-1:0]  C1_LAST = C1_W'(SCAN_TICKS - 1);
    localparam logic [C1_W-1:0]  C1_GAP  = C1_W'(GAP_TICKS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(BLINK_FRAMES - 1);

    // Scan state
    logic [C1_W-1:0]         r_c1;
    logic [IDX_W-1:0]        r_idx;
    logic [BCD_W*DIGITS-1:0] r_snap_num;
    logic [DIGITS-1:0]       r_snap_dp;
    logic [DIGITS-1:0]       r_snap_blink;
    logic                    r_phase;
    logic [FC_W-1:0]         r_fcnt;

    // Registered outputs
    logic [BCD_W-1:0]        r_number_data;
    logic                    r_dp_out;
    logic [DIGITS-1:0]       r_scan_sel;
    logic                    r_blank;
    logic                    r_frame_done;

    // Combinational helpers
    logic                    w_c1_last;
    logic                    w_frame_end;
    logic                    w_capture;
    logic [BCD_W*DIGITS-1:0] w_num;
    logic [DIGITS-1:0]       w_dp;
    logic [DIGITS-1:0]       w_blink;
    logic [DIGITS-1:0]       w_lz_mask;
    logic [BCD_W-1:0]        w_digit [DIGITS];
    logic [C1_W-1:0]         w_c1_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [FC_W-1:0]         w_fcnt_nxt;
    logic                    w_phase_nxt;
    logic                    w_lit;
    logic [DIGITS-1:0]       w_sel_nxt;
    logic [BCD_W-1:0]        w_data_nxt;
    logic                    w_dp_nxt;

    assign w_c1_last   = (r_c1 == C1_LAST);
    assign w_frame_end = Enable && w_c1_last && (r_idx == {IDX_W{1'b0}});
    assign w_capture   = Enable && (r_c1 == {C1_W{1'b0}}) && (r_idx == IDX_TOP);

    // In the capture cycle the live inputs are used directly so the first slot of a frame is already fresh
    assign w_num   = w_capture ? Number_Sig : r_snap_num;
    assign w_dp    = w_capture ? Dp_Sig     : r_snap_dp;
    assign w_blink = w_capture ? Blink_En   : r_snap_blink;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_digit[g] = w_num[g*BCD_W +: BCD_W];
    end

    smg_lz_mask #(
        .DIGITS (DIGITS)
    ) u_lz_mask (
        .i_digits (w_num),
        .i_dp     (w_dp),
        .i_lz_en  (Lz_En),
        .o_mask   (w_lz_mask)
    );

    // Next slot position and blink timebase; disable parks the scan at the top digit
    always_comb begin
        w_c1_nxt    = r_c1;
        w_idx_nxt   = r_idx;
        w_fcnt_nxt  = r_fcnt;
        w_phase_nxt = r_phase;
        if (!Enable) begin
            w_c1_nxt  = {C1_W{1'b0}};
            w_idx_nxt = IDX_TOP;
        end else begin
            if (w_c1_last) begin
                w_c1_nxt = {C1_W{1'b0}};
                if (r_idx == {IDX_W{1'b0}}) begin
                    w_idx_nxt = IDX_TOP;
                end else begin
                    w_idx_nxt = r_idx - {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end else begin
                w_c1_nxt = r_c1 + {{(C1_W-1){1'b0}}, 1'b1};
            end
            if (w_frame_end) begin
                if (r_fcnt == FC_LAST) begin
                    w_fcnt_nxt  = {FC_W{1'b0}};
                    w_phase_nxt = ~r_phase;
                end else begin
                    w_fcnt_nxt = r_fcnt + {{(FC_W-1){1'b0}}, 1'b1};
                end
            end else begin
                w_fcnt_nxt = r_fcnt;
            end
        end
    end

    // Decide what the digit drivers see next cycle from the current slot state
    always_comb begin
        w_lit = Enable && (r_c1 >= C1_GAP) && !w_lz_mask[r_idx] && !(r_phase && w_blink[r_idx]);
        if (w_lit) begin
            w_sel_nxt = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
        end else begin
            w_sel_nxt = {DIGITS{1'b0}};
        end
        if (Enable) begin
            w_data_nxt = w_digit[r_idx];
        end else begin
            w_data_nxt = r_number_data;
        end
        w_dp_nxt = w_dp[r_idx] & w_lit;
    end

    // Scan counters, blink timebase and frame snapshot
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_c1         <= {C1_W{1'b0}};
            r_idx        <= IDX_TOP;
            r_snap_num   <= {(BCD_W*DIGITS){1'b0}};
            r_snap_dp    <= {DIGITS{1'b0}};
            r_snap_blink <= {DIGITS{1'b0}};
            r_phase      <= 1'b0;
            r_fcnt       <= {FC_W{1'b0}};
        end else begin
            r_c1    <= w_c1_nxt;
            r_idx   <= w_idx_nxt;
            r_phase <= w_phase_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (w_capture) begin
                r_snap_num   <= Number_Sig;
                r_snap_dp    <= Dp_Sig;
                r_snap_blink <= Blink_En;
            end else begin
                r_snap_num   <= r_snap_num;
                r_snap_dp    <= r_snap_dp;
                r_snap_blink <= r_snap_blink;
            end
        end
    end

    // Output registers; reset forces the display dark at once
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_number_data <= {BCD_W{1'b0}};
            r_dp_out      <= 1'b0;
            r_scan_sel    <= {DIGITS{1'b0}};
            r_blank       <= 1'b1;
            r_frame_done  <= 1'b0;
        end else begin
            r_number_data <= w_data_nxt;
            r_dp_out      <= w_dp_nxt;
            r_scan_sel    <= w_sel_nxt;
            r_blank       <= ~|w_sel_nxt;
            r_frame_done  <= w_frame_end;
        end
    end

    assign Number_Data = r_number_data;
    assign Dp_Out      = r_dp_out;
    assign Scan_Sel    = r_scan_sel;
    assign Blank       = r_blank;
    assign Frame_Done  = r_frame_done;

endmodule

// File: doc/smg_scan_ctrl.md
Name: smg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment scan controller, the successor to the fixed 6-digit, 1 ms digit scanner. It time-multiplexes DIGITS BCD nibbles onto one shared 4-bit code bus and drives a one-hot digit select. It adds an anti-ghosting blank gap, per-digit decimal point, per-digit blink, leading-zero suppression, frame-coherent input snapshot, enable gating and a frame-done pulse. It sits between the number-formatting logic and the segment decoder / digit drivers.

Parameters:
DIGITS, 6, number of digits scanned (>=2); digit DIGITS-1 is the most significant and is scanned first.
SCAN_TICKS, 50000, CLK cycles per digit slot (1 ms at 50 MHz); must be >= GAP_TICKS+2.
GAP_TICKS, 2, cycles at the start of each slot with Scan_Sel all zero; must be >= 1.
BLINK_FRAMES, 250, frames per blink half-period.

Ports:
CLK  in  1  clock
RSTn  in  1  reset, asynchronous, active-low
Enable  in  1  scan enable; low = display dark, state held at start
Number_Sig  in  4*DIGITS  BCD digits; nibble k = digit k
Dp_Sig  in  DIGITS  decimal point request per digit
Blink_En  in  DIGITS  blink request per digit
Lz_En  in  1  leading-zero suppression enable
Number_Data  out  4  BCD code of the active digit
Dp_Out  out  1  decimal point of the active digit
Scan_Sel  out  DIGITS  one-hot digit select, active-high
Blank  out  1  1 = no digit lit in this cycle
Frame_Done  out  1  one-cycle pulse at the end of each full frame

Behaviour:
- Reset values: C1=0, idx=DIGITS-1, snapshot=0, blink phase=0, frame counter=0, Number_Data=0, Dp_Out=0, Scan_Sel=0, Blank=1, Frame_Done=0.
- Slot counter C1 runs 0..SCAN_TICKS-1 and wraps. At the wrap, idx decrements (DIGITS-1 down to 0, then back to DIGITS-1).
- Snapshot: Number_Sig, Dp_Sig and Blink_En are captured when C1==0 and idx==DIGITS-1. Input changes mid-frame take effect only at the next frame.
- All outputs are registered. The output value in cycle t+1 is computed from the state in cycle t.
- Scan_Sel bit idx is high only when all of the following hold:
  - C1 >= GAP_TICKS;
  - the digit is not suppressed;
  - the digit is not blinked off.
  Otherwise Scan_Sel is all zero.
- Blank = ~|Scan_Sel.
- Number_Data = snapshot nibble idx. It is updated for the whole slot, including the gap.
- Dp_Out = snapshot Dp bit idx AND Scan_Sel bit idx.
- Leading-zero suppression: digit k is suppressed when Lz_En=1 and every digit from DIGITS-1 down to k is zero. Digit 0 is never suppressed. A digit whose Dp bit is set is never suppressed.
- Blink: the frame counter counts frames; at BLINK_FRAMES-1 it wraps and toggles the blink phase. While phase=1, digits with Blink_En set in the snapshot are dark.
- Frame_Done is high for exactly one cycle: the cycle after C1==SCAN_TICKS-1 with idx==0.
- Enable low (sampled each cycle): C1=0, idx=DIGITS-1, Scan_Sel=0, Blank=1, Frame_Done=0. Snapshot, blink phase and frame counter hold. On re-enable, scanning restarts with a fresh snapshot in the first cycle.
- Async reset mid-slot: outputs take their reset values immediately, with no partial pulse on Frame_Done.
- Width rules:
  - C1 width is clog2(SCAN_TICKS).
  - idx width is max(1, clog2(DIGITS)).
  - The frame counter width is clog2(BLINK_FRAMES).
  - Comparisons are unsigned, with no overflow beyond the wrap points.

Decomposition:
- Package smg_pkg holds:
  - the T1MS_50MHZ=50000 constant;
  - a clog2-with-minimum-1 function;
  - the BCD nibble width constant 4.
- Sub-module smg_lz_mask: combinational DIGITS-wide suppression mask from snapshot digits, Dp bits and Lz_En. It is reusable by future display blocks.

Test Plan:
Bench parameters for all scenarios: DIGITS=4, SCAN_TICKS=8, GAP_TICKS=2, BLINK_FRAMES=2.
1. Reset, then Enable=1, Number_Sig=16'h1234, Lz_En=0 -> per 8-cycle slot, Scan_Sel is 0000 for 2 cycles, then 1000 for 6 cycles, with Number_Data=1. The next slots give 0100/2, 0010/3, 0001/4. Frame_Done pulses once every 32 cycles.
2. Number_Sig=16'h0050, Lz_En=1 -> digits 3 and 2 are dark (Scan_Sel=0, Blank=1 for the whole slot). Digits 1 and 0 light with values 5 and 0. With Number_Sig=0, only digit 0 lights.
3. Number_Sig changed from 16'h1234 to 16'h9876 during the digit-2 slot -> the rest of the frame still shows 3 and 4. The next frame shows 9, 8, 7, 6.
4. Blink_En=4'b0010 -> digit 1 is lit in frames 0-1, dark in frames 2-3, lit in frames 4-5. The other digits are unaffected. Dp_Sig=4'b0100 -> Dp_Out is high only while Scan_Sel=0100.
5. Enable dropped mid-slot -> next cycle Scan_Sel=0 and Blank=1. Enable raised -> digit 3 slot restarts at C1=0 with a fresh snapshot.
6. RSTn asserted mid-frame -> all outputs are at reset values within the same cycle, asynchronously. After release, scanning resumes from digit 3.
